neuron_lif_array: RTL
=====================

Name: neuron_lif_array

Overview:
Multi-channel leaky integrate-and-fire core. It holds N_NEURONS membrane potentials of V_WIDTH bits in registers, with per-neuron refractory counters and run-time threshold, leak and refractory configuration. Weighted events integrate into one neuron per cycle. A tick runs a sequential leak sweep over all neurons. Emitted bytes go into an internal OUT_DEPTH FIFO with a valid/ready handshake, and back-pressure stalls the block; nothing is dropped. The block sits between the event decoder and the serial output packer, and supersedes the single-neuron LIF mode.

Parameters:
N_NEURONS, 4, number of neurons; index width IDX_W = max(1, clog2(N_NEURONS)).
V_WIDTH, 8, membrane width; minimum 4.
W_WIDTH, 2, unsigned event-weight width.
REFRAC_W, 3, refractory counter width.
OUT_DEPTH, 2, output FIFO depth; minimum 1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_thr  in  V_WIDTH  fire threshold
cfg_leak_shift  in  3  leak shift
cfg_refrac  in  REFRAC_W  refractory ticks after fire
learn_en  in  1  enables learn_start_pulse
ev_valid  in  1  event offered
ev_ready  out  1  event accepted this cycle when high with ev_valid
ev_is_tick  in  1  1 = tick, 0 = weighted spike event
ev_idx  in  IDX_W  target neuron (spike event only)
ev_w  in  W_WIDTH  event weight
ev_stream_act  in  1  tick emits activity bytes
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pop
out_data  out  8  {1'b1, type[2:0], payload[3:0]}
post_spike_pulse  out  1  one-cycle fire strobe
learn_start_pulse  out  1  post_spike_pulse && learn_en
post_idx  out  IDX_W  neuron that fired, valid with the pulse
busy  out  1  sweep in progress
dbg_idx  in  IDX_W  debug read select
dbg_v  out  V_WIDTH  V[dbg_idx], combinational

Behaviour:
- Reset (asynchronous, active-low) clears:
  - all V and refractory counters to 0;
  - the FIFO to empty;
  - state to IDLE;
  - post_spike_pulse, learn_start_pulse and post_idx to 0.
  Resulting values: out_valid=0, busy=0, ev_ready=1. A reset mid-sweep abandons the sweep.
- Handshakes:
  - ev_ready = (state==IDLE) && (fifo_count < OUT_DEPTH). It depends only on registered state; a same-cycle pop does not count.
  - FIFO pops on out_valid && out_ready. out_data is the registered head. A push and a pop in the same cycle are both honoured.
- Spike event, accepted in IDLE with ev_is_tick=0, neuron i=ev_idx:
  - An ev_idx ≥ N_NEURONS is accepted and ignored.
  - If refrac[i] != 0, the event is ignored: V unchanged, no emit.
  - Otherwise sum = min(V[i] + ev_w, 2^V_WIDTH − 1).
  - If sum ≥ cfg_thr:
    - V[i] ← 0 and refrac[i] ← cfg_refrac;
    - push {1, `NEURON_TYPE_SPIKE, i[3:0] zero-extended};
    - assert post_spike_pulse, learn_start_pulse and post_idx on the next cycle, for one cycle.
  - Otherwise V[i] ← sum.
  - New V is visible on dbg_v the cycle after acceptance. A pushed byte gives out_valid the cycle after the push when the FIFO was empty.
- Tick, accepted in IDLE with ev_is_tick=1:
  - Latch ev_stream_act, go to SWEEP, busy=1, sweep pointer p=0.
  - Each SWEEP cycle processes neuron p:
    - V[p] ← V[p] − (V[p] >> cfg_leak_shift); shift 0 therefore clears V;
    - if refrac[p] != 0, decrement it by 1;
    - if stream_act is latched, push {1, `NEURON_TYPE_ACT, V[p][3:0]}, using the pre-leak value.
  - If a push is required and the FIFO is full, the cycle stalls: p, V and refrac are unchanged.
  - After p = N_NEURONS−1 is processed, return to IDLE.
  - Minimum tick latency is N_NEURONS cycles; ev_ready is low throughout.
- A tick never fires a neuron; leak is monotone non-increasing.
- cfg_* are sampled when used; software changes them only while idle.

Test Plan:
- Reset with V/FIFO populated, rst_n asserted mid-cycle -> outputs immediately 0, dbg_v=0 for every idx, ev_ready=1 after release.
- cfg_thr=32, cfg_refrac=0, 16 events idx1 w=2 -> dbg_v(1)=30 after 15; 16th fires: V=0, out_data=0x80|SPIKE<<4|0x1, post_spike_pulse one cycle with post_idx=1, learn_start_pulse only when learn_en=1.
- cfg_refrac=2, fire idx0, then 3 events w=3 idx0 -> V stays 0; after 2 ticks the same event gives V=3.
- V=[0,20,31,8], cfg_leak_shift=3, tick with stream_act, out_ready=1 -> payloads 0x0,0x4,0xF,0x8 in order; V becomes [0,18,28,7]; busy high 4 cycles.
- OUT_DEPTH=2, out_ready=0, three firing events -> ev_ready drops after the second push; the third is accepted only after one pop; no bytes are lost; a stream_act sweep stalls similarly.
- cfg_thr=255, V=254, w=3 -> sum saturates at 255 and fires; event to idx ≥ N_NEURONS (N_NEURONS=3, idx=3) -> accepted, no state change.

Source files
------------

// File: rtl/neuron_lif_array_if.sv
// Event-in / byte-out handshake bundle for neuron_lif_array.
//   ev_*  : event offer from the decoder (valid/ready)
//   out_* : emitted byte stream towards the serial packer (valid/ready)
// master = event source + byte consumer, slave = the LIF core.

`ifndef NEURON_TYPE_SPIKE
`define NEURON_TYPE_SPIKE 3'd1
`endif
`ifndef NEURON_TYPE_ACT
`define NEURON_TYPE_ACT 3'd2
`endif

interface neuron_lif_array_if #(
   parameter int IDX_W   = 2,
   parameter int W_WIDTH = 2
);
   logic               ev_valid;
   logic               ev_ready;
   logic               ev_is_tick;
   logic [IDX_W-1:0]   ev_idx;
   logic [W_WIDTH-1:0] ev_w;
   logic               ev_stream_act;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_data;

   modport master (
      output ev_valid, ev_is_tick, ev_idx, ev_w, ev_stream_act, out_ready,
      input  ev_ready, out_valid, out_data
   );

   modport slave (
      input  ev_valid, ev_is_tick, ev_idx, ev_w, ev_stream_act, out_ready,
      output ev_ready, out_valid, out_data
   );
endinterface

// File: rtl/neuron_lif_array.sv
// Multi-channel leaky integrate-and-fire core.
// Holds N_NEURONS membrane potentials with per-neuron refractory counters.
// Spike events integrate into one neuron per cycle; a tick runs a leak sweep
// over all neurons, one per cycle. Emitted bytes queue in an OUT_DEPTH FIFO;
// a full FIFO stalls the block, nothing is dropped.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bus (slave)           ev_* event handshake, out_* byte handshake
//   cfg_thr               fire threshold
//   cfg_leak_shift        leak = V >> shift (0 clears V on a tick)
//   cfg_refrac            refractory ticks loaded on fire
//   learn_en              gates learn_start_pulse
//   post_spike_pulse      one-cycle fire strobe, post_idx valid with it
//   learn_start_pulse     post_spike_pulse && learn_en
//   busy                  leak sweep in progress
//   dbg_idx / dbg_v       combinational membrane read-back
//
// state | meaning
// IDLE  | accepting events while the FIFO has room
// SWEEP | leaking neuron sweep_p, one per cycle; stalls on full FIFO when streaming

`ifndef NEURON_TYPE_SPIKE
`define NEURON_TYPE_SPIKE 3'd1
`endif
`ifndef NEURON_TYPE_ACT
`define NEURON_TYPE_ACT 3'd2
`endif

module neuron_lif_array #(
   parameter int  N_NEURONS = 4,
   parameter int  V_WIDTH   = 8,
   parameter int  W_WIDTH   = 2,
   parameter int  REFRAC_W  = 3,
   parameter int  OUT_DEPTH = 2,
   localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   neuron_lif_array_if.slave    bus,
   input  logic [V_WIDTH-1:0]   cfg_thr,
   input  logic [2:0]           cfg_leak_shift,
   input  logic [REFRAC_W-1:0]  cfg_refrac,
   input  logic                 learn_en,
   output logic                 post_spike_pulse,
   output logic                 learn_start_pulse,
   output logic [IDX_W-1:0]     post_idx,
   output logic                 busy,
   input  logic [IDX_W-1:0]     dbg_idx,
   output logic [V_WIDTH-1:0]   dbg_v
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
   localparam logic [IDX_W:0]   N_C      = (IDX_W + 1)'(N_NEURONS);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t               state;
   logic [V_WIDTH-1:0]   v      [N_NEURONS];
   logic [REFRAC_W-1:0]  refrac [N_NEURONS];
   logic [7:0]           fifo_mem [OUT_DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     fifo_count;
   logic [IDX_W-1:0]     sweep_p;
   logic                 stream_act;

   logic                 fifo_full;
   logic                 ev_accept;
   logic                 pop;
   logic                 push;
   logic [7:0]           push_data;
   logic                 ev_in_range;
   logic [IDX_W-1:0]     ev_sel;
   logic [V_WIDTH-1:0]   ev_v;
   logic [REFRAC_W-1:0]  ev_refrac;
   logic [V_WIDTH:0]     sum_wide;
   logic [V_WIDTH-1:0]   sum_sat;
   logic                 spike_ev;
   logic                 fire;
   logic [3:0]           ev_idx4;
   logic [V_WIDTH-1:0]   sweep_v;
   logic [V_WIDTH-1:0]   leak_v;
   logic                 sweep_stall;
   logic                 sweep_step;
   logic                 dbg_in_range;
   logic [IDX_W-1:0]     dbg_sel;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake terms use registered state only, so a same-cycle pop never
   // opens the event port.
   assign fifo_full     = (fifo_count == DEPTH_C);
   assign bus.ev_ready  = (state == IDLE) && !fifo_full;
   assign bus.out_valid = (fifo_count != '0);
   assign bus.out_data  = fifo_mem[rd_ptr];
   assign ev_accept     = bus.ev_valid && bus.ev_ready;
   assign pop           = bus.out_valid && bus.out_ready;
   assign busy          = (state == SWEEP);
   assign learn_start_pulse = post_spike_pulse && learn_en;

   // Out-of-range targets are folded onto neuron 0 for the read path only;
   // spike_ev masks them so no state is touched.
   assign ev_in_range = ({1'b0, bus.ev_idx} < N_C);
   assign ev_sel      = ev_in_range ? bus.ev_idx : '0;
   assign ev_v        = v[ev_sel];
   assign ev_refrac   = refrac[ev_sel];
   assign sum_wide    = {1'b0, ev_v} + (V_WIDTH + 1)'(bus.ev_w);
   assign sum_sat     = sum_wide[V_WIDTH] ? '1 : sum_wide[V_WIDTH-1:0];
   assign spike_ev    = ev_accept && !bus.ev_is_tick && ev_in_range && (ev_refrac == '0);
   assign fire        = spike_ev && (sum_sat >= cfg_thr);

   always_comb begin
      ev_idx4 = '0;
      for (int b = 0; b < 4 && b < IDX_W; b++) begin
         ev_idx4[b] = bus.ev_idx[b];
      end
   end

   assign sweep_v     = v[sweep_p];
   assign leak_v      = sweep_v - (sweep_v >> cfg_leak_shift);
   assign sweep_stall = stream_act && fifo_full;
   assign sweep_step  = (state == SWEEP) && !sweep_stall;

   // Fire and sweep pushes are mutually exclusive: fire needs IDLE.
   assign push      = fire || (sweep_step && stream_act);
   assign push_data = fire ? {1'b1, `NEURON_TYPE_SPIKE, ev_idx4}
                           : {1'b1, `NEURON_TYPE_ACT, sweep_v[3:0]};

   assign dbg_in_range = ({1'b0, dbg_idx} < N_C);
   assign dbg_sel      = dbg_in_range ? dbg_idx : '0;
   assign dbg_v        = dbg_in_range ? v[dbg_sel] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         sweep_p          <= '0;
         stream_act       <= 1'b0;
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         fifo_count       <= '0;
         post_spike_pulse <= 1'b0;
         post_idx         <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            v[i]      <= '0;
            refrac[i] <= '0;
         end
         for (int j = 0; j < OUT_DEPTH; j++) begin
            fifo_mem[j] <= '0;
         end
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= push_data;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + CNT_W'(1);
         end else if (!push && pop) begin
            fifo_count <= fifo_count - CNT_W'(1);
         end

         post_spike_pulse <= fire;
         if (fire) begin
            post_idx <= bus.ev_idx;
         end

         case (state)
            IDLE: begin
               if (ev_accept && bus.ev_is_tick) begin
                  state      <= SWEEP;
                  stream_act <= bus.ev_stream_act;
                  sweep_p    <= '0;
               end else if (spike_ev) begin
                  if (fire) begin
                     v[ev_sel]      <= '0;
                     refrac[ev_sel] <= cfg_refrac;
                  end else begin
                     v[ev_sel] <= sum_sat;
                  end
               end
            end
            SWEEP: begin
               if (sweep_step) begin
                  v[sweep_p] <= leak_v;
                  if (refrac[sweep_p] != '0) begin
                     refrac[sweep_p] <= refrac[sweep_p] - REFRAC_W'(1);
                  end
                  if (sweep_p == LAST_IDX) begin
                     state <= IDLE;
                  end else begin
                     sweep_p <= sweep_p + IDX_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
